// File: rtl/graph_mem_port_pkg.sv
// Shared encodings and defaults for the graph memory-port engine.
// Mode encodings, FSM state enum and default widths used by graph_mem_port.
package graph_mem_port_pkg;

    localparam int DEFAULT_MADDR_WIDTH = 16;
    localparam int DEFAULT_MDATA_WIDTH = 16;
    localparam int DEFAULT_INDEX_WIDTH = 8;
    localparam int DEFAULT_MAX_NODES   = 8;
    localparam int DEFAULT_TIMEOUT     = 64;

    typedef enum logic [1:0] {
        MODE_LOAD        = 2'd0,
        MODE_LOAD_VERIFY = 2'd1,
        MODE_DUMP_PREV   = 2'd2,
        MODE_RESERVED    = 2'd3
    } mode_t;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_WRITE  = 4'd2,
        S_WGAP   = 4'd3,
        S_VREAD  = 4'd4,
        S_VGAP   = 4'd5,
        S_READ   = 4'd6,
        S_RGAP   = 4'd7,
        S_EMIT   = 4'd8,
        S_FINISH = 4'd9
    } state_t;

endpackage

// File: rtl/graph_mem_port_mem_handshake.sv
// One enable/ready memory transaction: raise the enable on go, hold address/data
// until ready, capture read data, drop the enable, or give up after TIMEOUT cycles.
module mem_handshake #(
    parameter int AW      = 16,
    parameter int DW      = 16,
    parameter int TIMEOUT = 64
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          go_i,
    input  logic          write_i,
    input  logic [AW-1:0] addr_i,
    input  logic [DW-1:0] wdata_i,
    output logic          read_enable_o,
    output logic          write_enable_o,
    output logic [AW-1:0] addr_o,
    output logic [DW-1:0] wdata_o,
    input  logic          read_ready_i,
    input  logic          write_ready_i,
    input  logic [DW-1:0] read_data_i,
    output logic [DW-1:0] rdata_o,
    output logic          done_o,
    output logic          timeout_o
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic          rd_en_q;
    logic          wr_en_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic [DW-1:0] rdata_q;
    logic [CW-1:0] cnt_q;

    logic active;
    logic hit;
    logic expire;

    assign active = rd_en_q | wr_en_q;
    assign hit    = (rd_en_q & read_ready_i) | (wr_en_q & write_ready_i);
    assign expire = active & ~hit & (cnt_q == CW'(TIMEOUT - 1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_en_q <= 1'b0;
            wr_en_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            cnt_q   <= '0;
        end else if (go_i) begin
            wr_en_q <= write_i;
            rd_en_q <= ~write_i;
            addr_q  <= addr_i;
            wdata_q <= wdata_i;
            cnt_q   <= '0;
        end else if (hit || expire) begin
            // Enable drops the cycle after ready is sampled (or the wait expires).
            rd_en_q <= 1'b0;
            wr_en_q <= 1'b0;
            if (rd_en_q && read_ready_i) begin
                rdata_q <= read_data_i;
            end
        end else if (active) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    assign read_enable_o  = rd_en_q;
    assign write_enable_o = wr_en_q;
    assign addr_o         = addr_q;
    assign wdata_o        = wdata_q;
    assign rdata_o        = rdata_q;
    assign done_o         = hit;
    assign timeout_o      = expire;

endmodule

// File: rtl/graph_mem_port.sv
// Memory-port engine: streams an NxN weight matrix into BlockRam (optionally
// read-back verified) or streams the prev array out, one mem_handshake at a time.
module graph_mem_port
    import graph_mem_port_pkg::*;
#(
    parameter int MADDR_WIDTH = DEFAULT_MADDR_WIDTH,
    parameter int MDATA_WIDTH = DEFAULT_MDATA_WIDTH,
    parameter int INDEX_WIDTH = DEFAULT_INDEX_WIDTH,
    parameter int MAX_NODES   = DEFAULT_MAX_NODES,
    parameter int ADDR_STRIDE = MADDR_WIDTH / 8,
    parameter int TIMEOUT     = DEFAULT_TIMEOUT
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       start,
    input  logic [1:0]                 mode,
    input  logic [INDEX_WIDTH-1:0]     number_of_nodes,
    input  logic [MADDR_WIDTH-1:0]     base_address,
    input  logic [MDATA_WIDTH-1:0]     in_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [MDATA_WIDTH-1:0]     out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       mem_read_enable,
    output logic                       mem_write_enable,
    input  logic                       mem_read_ready,
    input  logic                       mem_write_ready,
    output logic [MADDR_WIDTH-1:0]     mem_addr,
    output logic [MDATA_WIDTH-1:0]     mem_write_data,
    input  logic [MDATA_WIDTH-1:0]     mem_read_data,
    output logic                       busy,
    output logic                       done,
    output logic                       error,
    output logic [2*INDEX_WIDTH-1:0]   error_index,
    output state_t                     dbg_state
);

    // Streams use valid/ready: a word moves on every cycle where both are 1.
    localparam int KW = 2 * INDEX_WIDTH;
    localparam logic [MADDR_WIDTH-1:0] STRIDE = MADDR_WIDTH'(ADDR_STRIDE);

    state_t                 state_q;
    mode_t                  mode_q;
    logic [INDEX_WIDTH-1:0] n_q;
    logic [KW-1:0]          nn_q;
    logic [KW-1:0]          k_q;
    logic [MADDR_WIDTH-1:0] addr_q;
    logic [MDATA_WIDTH-1:0] word_q;
    logic                   go_q;
    logic                   write_q;
    logic                   in_ready_q;
    logic                   out_valid_q;
    logic [MDATA_WIDTH-1:0] out_data_q;
    logic                   busy_q;
    logic                   done_q;
    logic                   error_q;
    logic [KW-1:0]          error_index_q;

    logic [KW-1:0]          nn_d;
    logic [MADDR_WIDTH-1:0] dump_base_d;
    logic                   bad_request_d;
    logic                   last_word_d;
    logic                   last_prev_d;
    logic                   hs_done;
    logic                   hs_timeout;
    logic [MDATA_WIDTH-1:0] hs_rdata;

    always_comb begin
        nn_d          = KW'(number_of_nodes) * KW'(number_of_nodes);
        // prev[] sits directly after the N*N matrix; wrap-around is intentional.
        dump_base_d   = base_address + MADDR_WIDTH'(nn_d) * STRIDE;
        bad_request_d = (mode_t'(mode) == MODE_RESERVED) || (int'(number_of_nodes) > MAX_NODES);
        last_word_d   = (k_q == nn_q - KW'(1));
        last_prev_d   = (k_q == KW'(n_q) - KW'(1));
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            mode_q        <= MODE_LOAD;
            n_q           <= '0;
            nn_q          <= '0;
            k_q           <= '0;
            addr_q        <= '0;
            word_q        <= '0;
            go_q          <= 1'b0;
            write_q       <= 1'b0;
            in_ready_q    <= 1'b0;
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            error_q       <= 1'b0;
            error_index_q <= '0;
        end else begin
            go_q   <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        mode_q        <= mode_t'(mode);
                        n_q           <= number_of_nodes;
                        nn_q          <= nn_d;
                        k_q           <= '0;
                        error_index_q <= '0;
                        error_q       <= bad_request_d;
                        if (bad_request_d || number_of_nodes == '0) begin
                            done_q  <= 1'b1;
                            state_q <= S_FINISH;
                        end else if (mode_t'(mode) == MODE_DUMP_PREV) begin
                            addr_q  <= dump_base_d;
                            busy_q  <= 1'b1;
                            go_q    <= 1'b1;
                            write_q <= 1'b0;
                            state_q <= S_READ;
                        end else begin
                            addr_q     <= base_address;
                            busy_q     <= 1'b1;
                            in_ready_q <= 1'b1;
                            state_q    <= S_FETCH;
                        end
                    end
                end
                S_FETCH: begin
                    if (in_valid && in_ready_q) begin
                        word_q     <= in_data;
                        in_ready_q <= 1'b0;
                        go_q       <= 1'b1;
                        write_q    <= 1'b1;
                        state_q    <= S_WRITE;
                    end
                end
                S_WRITE, S_VREAD, S_READ: begin
                    if (hs_timeout) begin
                        error_q       <= 1'b1;
                        error_index_q <= k_q;
                        busy_q        <= 1'b0;
                        done_q        <= 1'b1;
                        state_q       <= S_FINISH;
                    end else if (hs_done) begin
                        state_q <= (state_q == S_WRITE) ? S_WGAP :
                                   (state_q == S_VREAD) ? S_VGAP : S_RGAP;
                    end
                end
                S_WGAP, S_VGAP: begin
                    if (state_q == S_WGAP && mode_q == MODE_LOAD_VERIFY) begin
                        go_q    <= 1'b1;
                        write_q <= 1'b0;
                        state_q <= S_VREAD;
                    end else begin
                        // Only the first mismatch is recorded; the load keeps going.
                        if (state_q == S_VGAP && hs_rdata != word_q && !error_q) begin
                            error_q       <= 1'b1;
                            error_index_q <= k_q;
                        end
                        if (last_word_d) begin
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= S_FINISH;
                        end else begin
                            k_q        <= k_q + KW'(1);
                            addr_q     <= addr_q + STRIDE;
                            in_ready_q <= 1'b1;
                            state_q    <= S_FETCH;
                        end
                    end
                end
                S_RGAP: begin
                    out_data_q  <= hs_rdata;
                    out_valid_q <= 1'b1;
                    state_q     <= S_EMIT;
                end
                S_EMIT: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        if (last_prev_d) begin
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= S_FINISH;
                        end else begin
                            k_q     <= k_q + KW'(1);
                            addr_q  <= addr_q + STRIDE;
                            go_q    <= 1'b1;
                            write_q <= 1'b0;
                            state_q <= S_READ;
                        end
                    end
                end
                S_FINISH: state_q <= S_IDLE;
                default:  state_q <= S_IDLE;
            endcase
        end
    end

    mem_handshake #(
        .AW      (MADDR_WIDTH),
        .DW      (MDATA_WIDTH),
        .TIMEOUT (TIMEOUT)
    ) u_hs (
        .clk_i          (clock),
        .rst_ni         (reset),
        .go_i           (go_q),
        .write_i        (write_q),
        .addr_i         (addr_q),
        .wdata_i        (word_q),
        .read_enable_o  (mem_read_enable),
        .write_enable_o (mem_write_enable),
        .addr_o         (mem_addr),
        .wdata_o        (mem_write_data),
        .read_ready_i   (mem_read_ready),
        .write_ready_i  (mem_write_ready),
        .read_data_i    (mem_read_data),
        .rdata_o        (hs_rdata),
        .done_o         (hs_done),
        .timeout_o      (hs_timeout)
    );

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign error       = error_q;
    assign error_index = error_index_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_graph_mem_port.sv
// Directed bench for graph_mem_port: vector table of whole operations against a
// behavioural BlockRam, plus hand sequences for busy/start and mid-load reset.
module tb_graph_mem_port;
    import graph_mem_port_pkg::*;

    localparam int AW   = 16;
    localparam int DW   = 16;
    localparam int IW   = 8;
    localparam int TMO  = 64;

    logic            clock = 1'b0;
    logic            reset = 1'b0;
    logic            start = 1'b0;
    logic [1:0]      mode = '0;
    logic [IW-1:0]   number_of_nodes = '0;
    logic [AW-1:0]   base_address = '0;
    logic [DW-1:0]   in_data = '0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [DW-1:0]   out_data;
    logic            out_valid;
    logic            out_ready = 1'b1;
    logic            mem_read_enable;
    logic            mem_write_enable;
    logic            mem_read_ready = 1'b0;
    logic            mem_write_ready = 1'b0;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_write_data;
    logic [DW-1:0]   mem_read_data = '0;
    logic            busy;
    logic            done;
    logic            error;
    logic [2*IW-1:0] error_index;
    state_t          dbg_state;

    graph_mem_port dut (
        .clock            (clock),
        .reset            (reset),
        .start            (start),
        .mode             (mode),
        .number_of_nodes  (number_of_nodes),
        .base_address     (base_address),
        .in_data          (in_data),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .out_data         (out_data),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .mem_read_enable  (mem_read_enable),
        .mem_write_enable (mem_write_enable),
        .mem_read_ready   (mem_read_ready),
        .mem_write_ready  (mem_write_ready),
        .mem_addr         (mem_addr),
        .mem_write_data   (mem_write_data),
        .mem_read_data    (mem_read_data),
        .busy             (busy),
        .done             (done),
        .error            (error),
        .error_index      (error_index),
        .dbg_state        (dbg_state)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clock = ~clock;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- memory model and monitors ----------------
    logic [DW-1:0] mem [0:32767];
    bit            mem_init_done = 1'b0;
    int            lat = 0;
    int            corrupt_idx = -1;
    bit            wr_stuck = 1'b0;
    bit            toggle = 1'b0;
    int            lat_cnt = 0;
    int            nwrites = 0;
    int            nreads = 0;
    int            wen_cycles = 0;
    int            done_cnt = 0;
    int            overlap_cnt = 0;

    always @(negedge clock) begin
        if (!mem_init_done) begin
            for (int i = 0; i < 32768; i++) mem[i] = '0;
            mem[16] = 16'd0;
            mem[17] = 16'd0;
            mem[18] = 16'd1;
            mem[19] = 16'd2;
            mem_init_done = 1'b1;
        end
        done_cnt += int'(done);
        if (done && busy) overlap_cnt++;
        if (mem_write_enable) wen_cycles++;
        mem_write_ready = 1'b0;
        mem_read_ready  = 1'b0;
        if (mem_write_enable && !wr_stuck) begin
            if (lat_cnt >= lat) begin
                mem_write_ready = 1'b1;
                mem[mem_addr[15:1]] = mem_write_data;
                nwrites++;
                lat_cnt = 0;
            end else lat_cnt++;
        end else if (mem_read_enable) begin
            if (lat_cnt >= lat) begin
                mem_read_ready = 1'b1;
                mem_read_data = (int'(mem_addr[15:1]) == corrupt_idx) ? ~mem[mem_addr[15:1]]
                                                                      : mem[mem_addr[15:1]];
                nreads++;
                lat_cnt = 0;
            end else lat_cnt++;
        end else begin
            lat_cnt = 0;
        end
    end

    logic [DW-1:0] got_q[$];
    always @(negedge clock) begin
        out_ready = toggle ? ~out_ready : 1'b1;
        if (out_valid && out_ready) got_q.push_back(out_data);
    end

    // ---------------- scoreboard ----------------
    int            checks = 0;
    int            failures = 0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] words [0:255];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic feed_words(input int n);
        int guard;
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_data  = words[i];
            guard = 0;
            while (!in_ready && guard < 500) begin
                @(negedge clock);
                guard++;
            end
            @(negedge clock);
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input int d0);
        int guard;
        guard = 0;
        while (done_cnt == d0 && guard < 3000) begin
            @(negedge clock);
            guard++;
        end
    endtask

    typedef struct {
        logic [1:0]  mode;
        int          n;
        logic [15:0] base;
        int          lat;
        int          corrupt;
        bit          stuck;
        bit          toggle;
        int          feed;
        bit          exp_err;
        int          exp_eidx;
        int          exp_writes;
        int          exp_reads;
        int          exp_wen;
        bit          check_mem;
    } vec_t;

    vec_t vecs [9];

    task automatic run_vec(input vec_t v, input int vi);
        int d0, w0, r0, c0, g0, bad;
        logic [AW-1:0] a;
        lat = v.lat;
        corrupt_idx = v.corrupt;
        wr_stuck = v.stuck;
        toggle = v.toggle;
        for (int k = 0; k < 256; k++) words[k] = DW'(vi * 16 + k + 1);
        exp_q.delete();
        if (v.mode == 2'd2) exp_q = '{16'd0, 16'd0, 16'd1, 16'd2};
        d0 = done_cnt; w0 = nwrites; r0 = nreads; c0 = wen_cycles; g0 = got_q.size();
        start = 1'b1;
        mode = v.mode;
        number_of_nodes = IW'(v.n);
        base_address = v.base;
        @(negedge clock);
        start = 1'b0;
        feed_words(v.feed);
        wait_done(d0);
        repeat (3) @(negedge clock);
        check($sformatf("v%0d done_pulses", vi), done_cnt - d0, 1);
        check($sformatf("v%0d error", vi), error, v.exp_err);
        check($sformatf("v%0d error_index", vi), error_index, v.exp_eidx);
        check($sformatf("v%0d writes", vi), nwrites - w0, v.exp_writes);
        check($sformatf("v%0d reads", vi), nreads - r0, v.exp_reads);
        check($sformatf("v%0d wen_cycles", vi), wen_cycles - c0, v.exp_wen);
        check($sformatf("v%0d idle_outputs", vi),
              {busy, in_ready, out_valid, mem_read_enable, mem_write_enable}, 0);
        check($sformatf("v%0d state", vi), dbg_state, S_IDLE);
        if (v.check_mem) begin
            bad = 0;
            for (int k = 0; k < v.exp_writes; k++) begin
                a = v.base + AW'(k * 2);
                if (mem[a[15:1]] !== words[k]) bad++;
            end
            check($sformatf("v%0d mem_words_bad", vi), bad, 0);
        end
        if (v.mode == 2'd2) begin
            check($sformatf("v%0d stream_len", vi), got_q.size() - g0, exp_q.size());
            for (int j = 0; j < exp_q.size() && g0 + j < got_q.size(); j++)
                check($sformatf("v%0d stream[%0d]", vi, j), got_q[g0 + j], exp_q[j]);
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin : main
        int d0, w0;
        //          mode  n  base     lat cor stk tog feed err eidx wr rd wen mem
        vecs[0] = '{2'd0, 3, 16'h0000, 0, -1, 0, 0, 9,  0, 0, 9, 0, 9,  1};
        vecs[1] = '{2'd1, 2, 16'h0000, 1,  2, 0, 0, 4,  1, 2, 4, 4, 8,  1};
        vecs[2] = '{2'd2, 4, 16'h0000, 2, -1, 0, 1, 0,  0, 0, 0, 4, 0,  0};
        vecs[3] = '{2'd0, 0, 16'h0000, 0, -1, 0, 0, 0,  0, 0, 0, 0, 0,  0};
        vecs[4] = '{2'd0, 9, 16'h0000, 0, -1, 0, 0, 0,  1, 0, 0, 0, 0,  0};
        vecs[5] = '{2'd3, 2, 16'h0000, 0, -1, 0, 0, 0,  1, 0, 0, 0, 0,  0};
        vecs[6] = '{2'd1, 3, 16'h0040, 3, -1, 0, 0, 9,  0, 0, 9, 9, 36, 1};
        vecs[7] = '{2'd0, 2, 16'h0000, 0, -1, 1, 0, 1,  1, 0, 0, 0, TMO, 0};
        vecs[8] = '{2'd0, 2, 16'hFFFC, 0, -1, 0, 0, 4,  0, 0, 4, 0, 4,  1};

        repeat (2) @(negedge clock);
        check("reset_flags", {busy, done, error, in_ready, out_valid, mem_read_enable, mem_write_enable}, 0);
        check("reset_error_index", error_index, 0);
        check("reset_mem_bus", {mem_addr, mem_write_data}, 0);
        check("reset_out_data", out_data, 0);
        reset = 1'b1;
        repeat (2) @(negedge clock);

        for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

        // start while busy must be ignored
        lat = 1; wr_stuck = 1'b0; corrupt_idx = -1; toggle = 1'b0;
        words[0] = 16'hABCD;
        d0 = done_cnt; w0 = nwrites;
        start = 1'b1; mode = 2'd0; number_of_nodes = 8'd1; base_address = 16'h0100;
        @(negedge clock);
        start = 1'b0;
        check("busy_after_start", busy, 1);
        check("in_ready_after_start", in_ready, 1);
        start = 1'b1; mode = 2'd3;
        @(negedge clock);
        start = 1'b0;
        feed_words(1);
        wait_done(d0);
        repeat (10) @(negedge clock);
        check("busy_seq done_pulses", done_cnt - d0, 1);
        check("busy_seq error", error, 0);
        check("busy_seq writes", nwrites - w0, 1);
        check("busy_seq mem", mem[16'h0080], 16'hABCD);

        // reset in the middle of a LOAD at k=5
        lat = 0; mode = 2'd0;
        for (int k = 0; k < 16; k++) words[k] = 16'h5000 + 16'(k);
        start = 1'b1; number_of_nodes = 8'd3; base_address = 16'h0000;
        @(negedge clock);
        start = 1'b0;
        feed_words(6);
        @(negedge clock);
        check("k5 write_enable", mem_write_enable, 1);
        check("k5 mem_addr", mem_addr, 16'd10);
        check("k5 write_data", mem_write_data, 16'h5005);
        reset = 1'b0;
        #1;
        check("midreset_flags", {busy, done, error, in_ready, out_valid, mem_read_enable, mem_write_enable}, 0);
        check("midreset_bus", {mem_addr, mem_write_data, out_data, error_index}, 0);
        check("midreset_state", dbg_state, S_IDLE);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        run_vec(vecs[0], 10);

        check("busy_during_done", overlap_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/graph_mem_port.md
# graph_mem_port

Parametrised memory-port engine for the Dijkstra datapath: loads an N×N edge-weight matrix from a valid/ready stream into BlockRam and reads the `prev` result array back out as a stream. It implements the load, verify and dump sequences in hardware and adds mode select, read-back verification, error reporting and handshake timeouts. It sits beside DijkstraTop on the shared BlockRam port; the top level muxes the memory bus to this block while `busy` is high.

## Interface
- `MADDR_WIDTH`, `DEFAULT_MADDR_WIDTH`: memory address width.
- `MDATA_WIDTH`, `DEFAULT_MDATA_WIDTH`: memory data width.
- `INDEX_WIDTH`, `DEFAULT_INDEX_WIDTH`: node index width.
- `MAX_NODES`, `DEFAULT_MAX_NODES`: largest legal `number_of_nodes`.
- `ADDR_STRIDE`, `MADDR_WIDTH/8`: address increment per word.
- `TIMEOUT`, 64: maximum cycles to wait for a memory ready.

Ports:
- `clock` in 1: sole clock, rising edge.
- `reset` in 1: asynchronous, active-low.
- `start` in 1: begin an operation; sampled only in IDLE.
- `mode` in 2: 0 LOAD, 1 LOAD_VERIFY, 2 DUMP_PREV, 3 reserved. Latched with `start`.
- `number_of_nodes` in INDEX_WIDTH: N. Latched with `start`.
- `base_address` in MADDR_WIDTH: matrix base. Latched with `start`.
- `in_data` / `in_valid` / `in_ready`: in MDATA_WIDTH / in 1 / out 1. Edge weight stream, row-major.
- `out_data` / `out_valid` / `out_ready`: out MDATA_WIDTH / out 1 / in 1. `prev` stream, index 0 first.
- `mem_read_enable`, `mem_write_enable` out 1; `mem_read_ready`, `mem_write_ready` in 1.
- `mem_addr` out MADDR_WIDTH; `mem_write_data` out MDATA_WIDTH; `mem_read_data` in MDATA_WIDTH.
- `busy` out 1; `done` out 1 (one-cycle pulse); `error` out 1; `error_index` out 2*INDEX_WIDTH.

## Operation
- States: IDLE, FETCH, WRITE, WGAP, VREAD, VGAP, READ, RGAP, EMIT, FINISH.
- LOAD: for k = 0..N²−1: FETCH (`in_ready`=1) accepts a word, then WRITE at `base + k*ADDR_STRIDE`, then WGAP, then the next FETCH.
- LOAD_VERIFY: as LOAD, but WGAP is followed by VREAD at the same address and then VGAP. On a mismatch, `error` is set, `error_index` holds the first failing k, and the operation continues.
- DUMP_PREV: for j = 0..N−1: READ at `base + (N²+j)*ADDR_STRIDE`, then RGAP, then EMIT (hold `out_data` until `out_ready`).
- Entering FINISH pulses `done` and returns to IDLE.
- Word counter is 2*INDEX_WIDTH bits. Address arithmetic is done modulo 2^MADDR_WIDTH, so wrap-around is silent.
- Boundary cases:
  - N=0: FINISH directly; no memory access and no stream activity.
  - N>MAX_NODES or mode 3: `error`=1, `error_index`=0, then FINISH with no access.
  - Memory ready not seen within TIMEOUT cycles: deassert the enable, set `error`, record k or j in `error_index`, then FINISH.
  - `start` while busy: ignored.
  - `error` is cleared only by the next accepted `start`.
  - Reset mid-operation: immediately IDLE; in-flight data is abandoned.

## Timing
- Reset values: every output 0.
- Accepted `start` makes `busy`=1 on the next cycle. `busy` falls in the same cycle `done` pulses.
- Stream transfer occurs on any cycle where valid and ready are both 1.
- Enables rise the cycle after state entry. Enable, address and data are held stable until ready is sampled 1. The enable drops on the following cycle, followed by at least one idle gap cycle (the GAP states).
- Read data is captured on the cycle `mem_read_ready`=1.
- `out_valid` rises the cycle after capture.
- Minimum LOAD cost per word: 1 (fetch) + 1 (enable) + ready latency + 1 (gap).

## Structure
- A shared package (with `constants.v`) holds the mode encodings, the state enum and the default TIMEOUT.
- A single sub-module, `mem_handshake`, owns one enable/ready transaction: request, hold, timeout counter, release and gap. The top FSM instantiates one `mem_handshake` and sequences it for both reads and writes.

## Test plan
- LOAD, N=3, weights 1..9, base 0: memory words 0..8 hold 1..9; one `done` pulse; `error`=0.
- LOAD_VERIFY, N=2, memory model corrupts address 2*ADDR_STRIDE: `error`=1, `error_index`=2, all four words written, `done` pulses.
- DUMP_PREV, N=4, prev preloaded {0,0,1,2} at words 16..19, `out_ready` toggling every cycle: stream emits 0,0,1,2 in order with no loss or duplication.
- N=0, then N=MAX_NODES+1: `done` pulses with no mem enables; `error` 0 and 1 respectively.
- `mem_write_ready` held 0: `error` after TIMEOUT cycles, `error_index`=0, enable low, `done` pulses.
- `reset` asserted mid-LOAD at k=5: all outputs 0 immediately; a new `start` works normally.
